// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_fb_arbiter: shares one single-port frame-buffer RAM between the VGA   |
// | scan-out reader (fixed-latency, always first) and a valid/ready writer.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module vga_fb_arbiter #(
   parameter int unsigned ADDR_W        = 12,
   parameter int unsigned PIX_W         = 9,
   parameter int unsigned WR_BLANK_ONLY = 0,
   parameter int unsigned STARVE_MAX    = 1023,
   parameter int unsigned CNT_W         = 10
) (
   input  logic              i_Clk,
   input  logic              i_Rst,
   input  logic              i_Blank,
   input  logic              i_Frame_Start,
   input  logic              i_Rd_Req,
   input  logic [ADDR_W-1:0] i_Rd_Addr,
   output logic [PIX_W-1:0]  o_Rd_Data,
   output logic              o_Rd_Valid,
   input  logic              i_Wr_Valid,
   input  logic [ADDR_W-1:0] i_Wr_Addr,
   input  logic [PIX_W-1:0]  i_Wr_Data,
   output logic              o_Wr_Ready,
   output logic [ADDR_W-1:0] o_Mem_Addr,
   output logic              o_Mem_We,
   output logic [PIX_W-1:0]  o_Mem_Wdata,
   input  logic [PIX_W-1:0]  i_Mem_Rdata,
   output logic              o_Wr_Starve,
   output logic [15:0]       o_Wr_Count
);

   localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_MAX);
   localparam logic [15:0]      C_COUNT_SAT  = 16'hFFFF;

   typedef enum logic [1:0] {
      PORT_IDLE = 2'd0,
      PORT_RD   = 2'd1,
      PORT_WR   = 2'd2
   } port_t;

   if ((64'd1 << CNT_W) <= 64'(STARVE_MAX)) begin : g_cnt_w_check
      $error("CNT_W too narrow to hold STARVE_MAX");
   end

   port_t            w_port;
   logic             w_permit;
   logic             w_xfer;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] r_starve_cnt;
   logic             r_rd_s1;
   logic             r_rd_s2;

   always_comb begin
      w_permit   = (WR_BLANK_ONLY == 0) || i_Blank;
      o_Wr_Ready = !i_Rst && !i_Rd_Req && w_permit;
      w_xfer     = i_Wr_Valid && o_Wr_Ready;
      w_port     = PORT_IDLE;
      if (i_Rd_Req) begin
         w_port = PORT_RD;
      end else if (w_xfer) begin
         w_port = PORT_WR;
      end
   end

   // A held-but-blocked writer is the only case that advances the counter.
   always_comb begin
      w_cnt_nxt = r_starve_cnt;
      if (i_Frame_Start || !i_Wr_Valid || w_xfer) begin
         w_cnt_nxt = '0;
      end else if (r_starve_cnt != C_STARVE_MAX) begin
         w_cnt_nxt = r_starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         o_Mem_Addr  <= '0;
         o_Mem_We    <= 1'b0;
         o_Mem_Wdata <= '0;
      end else begin
         o_Mem_We <= 1'b0;
         case (w_port)
            PORT_RD: o_Mem_Addr <= i_Rd_Addr;
            PORT_WR: begin
               o_Mem_Addr  <= i_Wr_Addr;
               o_Mem_Wdata <= i_Wr_Data;
               o_Mem_We    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Address register, RAM register, then capture: result lands two edges
   // after the address is presented.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_rd_s1    <= 1'b0;
         r_rd_s2    <= 1'b0;
         o_Rd_Valid <= 1'b0;
         o_Rd_Data  <= '0;
      end else begin
         r_rd_s1    <= i_Rd_Req;
         r_rd_s2    <= r_rd_s1;
         o_Rd_Valid <= r_rd_s2;
         if (r_rd_s2) begin
            o_Rd_Data <= i_Mem_Rdata;
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_starve_cnt <= '0;
         o_Wr_Starve  <= 1'b0;
      end else begin
         r_starve_cnt <= w_cnt_nxt;
         if (i_Frame_Start) begin
            o_Wr_Starve <= 1'b0;
         end else if (w_cnt_nxt == C_STARVE_MAX) begin
            o_Wr_Starve <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         o_Wr_Count <= '0;
      end else if (i_Frame_Start) begin
         o_Wr_Count <= w_xfer ? 16'd1 : 16'd0;
      end else if (w_xfer && (o_Wr_Count != C_COUNT_SAT)) begin
         o_Wr_Count <= o_Wr_Count + 16'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vga_fb_arbiter: scoreboard bench for vga_fb_arbiter with a 1-cycle     |
// | synchronous RAM model. Rev 1.0                                            |
// +--------------------------------------------------------------------------+
module tb_vga_fb_arbiter;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned PIX_W  = 9;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              blank = 1'b1;
   logic              frame_start = 1'b0;
   logic              rd_req = 1'b0;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic [PIX_W-1:0]  rd_data;
   logic              rd_valid;
   logic              wr_valid = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [PIX_W-1:0]  wr_data = '0;
   logic              wr_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [PIX_W-1:0]  mem_wdata;
   logic [PIX_W-1:0]  mem_rdata;
   logic              wr_starve;
   logic [15:0]       wr_count;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [PIX_W-1:0] sb_data [$];
   int               sb_cyc  [$];
   logic [PIX_W-1:0] sh      [0:(1<<ADDR_W)-1];

   logic [PIX_W-1:0] ram     [0:(1<<ADDR_W)-1];
   bit               written [0:(1<<ADDR_W)-1];

   vga_fb_arbiter #(
      .ADDR_W(ADDR_W), .PIX_W(PIX_W), .WR_BLANK_ONLY(1), .STARVE_MAX(7), .CNT_W(3)
   ) dut (
      .i_Clk(clk), .i_Rst(rst), .i_Blank(blank), .i_Frame_Start(frame_start),
      .i_Rd_Req(rd_req), .i_Rd_Addr(rd_addr), .o_Rd_Data(rd_data), .o_Rd_Valid(rd_valid),
      .i_Wr_Valid(wr_valid), .i_Wr_Addr(wr_addr), .i_Wr_Data(wr_data), .o_Wr_Ready(wr_ready),
      .o_Mem_Addr(mem_addr), .o_Mem_We(mem_we), .o_Mem_Wdata(mem_wdata),
      .i_Mem_Rdata(mem_rdata), .o_Wr_Starve(wr_starve), .o_Wr_Count(wr_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Unwritten locations read back as addr+5.
   always @(posedge clk) begin
      if (mem_we) begin
         ram[mem_addr]     <= mem_wdata;
         written[mem_addr] <= 1'b1;
      end
      mem_rdata <= written[mem_addr] ? ram[mem_addr] : PIX_W'(int'(mem_addr) + 5);
   end

   always @(negedge clk) begin
      if (rd_valid) begin
         n_checks++;
         if (sb_data.size() == 0) begin
            $display("FAIL rd_unexpected: o_Rd_Valid=1 data=%h at cycle %0d, required no result", rd_data, cyc);
         end else begin
            logic [PIX_W-1:0] exp_d;
            int               exp_c;
            exp_d = sb_data.pop_front();
            exp_c = sb_cyc.pop_front();
            if (rd_data !== exp_d || cyc != exp_c)
               $display("FAIL rd_result: got data=%h cycle=%0d, required data=%h cycle=%0d", rd_data, cyc, exp_d, exp_c);
            else
               n_pass++;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_read(input logic [ADDR_W-1:0] a);
      rd_req  = 1'b1;
      rd_addr = a;
      sb_data.push_back(sh[a]);
      sb_cyc.push_back(cyc + 3);
   endtask

   task automatic test_reset;
      wr_valid = 1'b1;
      tick; tick;
      @(negedge clk);
      n_checks++;
      if ({rd_data, rd_valid, mem_addr, mem_we, mem_wdata, wr_starve, wr_count} !== '0)
         $display("FAIL reset_outputs: got rd_data=%h rd_valid=%b addr=%h we=%b wdata=%h starve=%b count=%0d, required all 0",
                  rd_data, rd_valid, mem_addr, mem_we, mem_wdata, wr_starve, wr_count);
      else n_pass++;
      n_checks++;
      if (wr_ready !== 1'b0) $display("FAIL reset_ready: got %b, required 0", wr_ready);
      else n_pass++;
      tick;
      rst = 1'b0; wr_valid = 1'b0;
   endtask

   task automatic test_reads;
      for (int i = 0; i < 4; i++) begin
         tick;
         push_read(ADDR_W'(i));
         @(negedge clk);
         n_checks++;
         if (mem_we !== 1'b0) $display("FAIL reads_we: got %b, required 0", mem_we);
         else n_pass++;
      end
      tick;
      rd_req = 1'b0;
      repeat (6) begin
         @(negedge clk);
         n_checks++;
         if (mem_we !== 1'b0) $display("FAIL reads_we_tail: got %b, required 0", mem_we);
         else n_pass++;
         tick;
      end
      @(negedge clk);
      n_checks++;
      if (rd_valid !== 1'b0 || rd_data !== 9'd8)
         $display("FAIL reads_hold: got valid=%b data=%h, required valid=0 data=008", rd_valid, rd_data);
      else n_pass++;
   endtask

   task automatic test_write;
      tick;
      wr_valid = 1'b1; wr_addr = 12'h010; wr_data = 9'h1AB;
      sh[12'h010] = 9'h1AB;
      @(negedge clk);
      n_checks++;
      if (wr_ready !== 1'b1) $display("FAIL write_ready: got %b, required 1", wr_ready);
      else n_pass++;
      tick;
      wr_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem_we !== 1'b1 || mem_addr !== 12'h010 || mem_wdata !== 9'h1AB)
         $display("FAIL write_drive: got we=%b addr=%h wdata=%h, required 1/010/1ab", mem_we, mem_addr, mem_wdata);
      else n_pass++;
      tick;
      @(negedge clk);
      n_checks++;
      if (mem_we !== 1'b0 || mem_addr !== 12'h010 || mem_wdata !== 9'h1AB)
         $display("FAIL idle_hold: got we=%b addr=%h wdata=%h, required 0/010/1ab", mem_we, mem_addr, mem_wdata);
      else n_pass++;
      tick;
      push_read(12'h010);
      tick;
      rd_req = 1'b0;
      wr_valid = 1'b1; wr_addr = 12'h020; wr_data = 9'h055;
      sh[12'h020] = 9'h055;
      tick;
      wr_valid = 1'b0;
      push_read(12'h020);
      tick;
      rd_req = 1'b0;
      repeat (5) tick;
   endtask

   task automatic test_back_to_back;
      tick;
      wr_valid = 1'b1; wr_addr = 12'h030; wr_data = 9'h0F0;
      for (int i = 0; i < 3; i++) begin
         push_read(ADDR_W'(i));
         @(negedge clk);
         n_checks++;
         if (wr_ready !== 1'b0) $display("FAIL conflict_ready: got %b, required 0 (cycle %0d)", wr_ready, i);
         else n_pass++;
         tick;
      end
      rd_req = 1'b0;
      sh[12'h030] = 9'h0F0;
      @(negedge clk);
      n_checks++;
      if (wr_ready !== 1'b1) $display("FAIL conflict_release: got %b, required 1", wr_ready);
      else n_pass++;
      tick;
      wr_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem_we !== 1'b1 || mem_addr !== 12'h030 || mem_wdata !== 9'h0F0)
         $display("FAIL conflict_land: got we=%b addr=%h wdata=%h, required 1/030/0f0", mem_we, mem_addr, mem_wdata);
      else n_pass++;
      tick;
      push_read(12'h030);
      tick;
      rd_req = 1'b0;
      repeat (5) tick;
   endtask

   task automatic test_blank_only;
      blank = 1'b0;
      wr_valid = 1'b1; wr_addr = 12'h040; wr_data = 9'h0AA;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (wr_ready !== 1'b0 || mem_we !== 1'b0)
            $display("FAIL blank_block: got ready=%b we=%b, required 0/0 (cycle %0d)", wr_ready, mem_we, i);
         else n_pass++;
         tick;
      end
      blank = 1'b1;
      sh[12'h040] = 9'h0AA;
      @(negedge clk);
      n_checks++;
      if (wr_ready !== 1'b1) $display("FAIL blank_ready: got %b, required 1", wr_ready);
      else n_pass++;
      tick;
      wr_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem_we !== 1'b1 || mem_addr !== 12'h040)
         $display("FAIL blank_land: got we=%b addr=%h, required 1/040", mem_we, mem_addr);
      else n_pass++;
      tick;
   endtask

   task automatic test_starve;
      frame_start = 1'b1;
      tick;
      frame_start = 1'b0;
      wr_valid = 1'b1; wr_addr = 12'h050; wr_data = 9'h123;
      for (int i = 0; i < 9; i++) begin
         push_read(ADDR_W'(12'h100 + i));
         @(negedge clk);
         n_checks++;
         if (wr_starve !== (i >= 7))
            $display("FAIL starve_rise: got %b after %0d blocked cycles, required %b", wr_starve, i, (i >= 7));
         else n_pass++;
         tick;
      end
      rd_req = 1'b0;
      sh[12'h050] = 9'h123;
      tick;
      wr_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (wr_starve !== 1'b1) $display("FAIL starve_sticky: got %b, required 1", wr_starve);
      else n_pass++;
      tick;
      frame_start = 1'b1;
      tick;
      frame_start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (wr_starve !== 1'b0) $display("FAIL starve_clear: got %b, required 0", wr_starve);
      else n_pass++;
      tick;
   endtask

   task automatic test_count;
      frame_start = 1'b1;
      tick;
      frame_start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (wr_count !== 16'd0) $display("FAIL count_frame: got %0d, required 0", wr_count);
      else n_pass++;
      for (int i = 0; i < 20; i++) begin
         tick;
         wr_valid = 1'b1; wr_addr = ADDR_W'(12'h200 + i); wr_data = PIX_W'(i);
         sh[12'h200 + i] = PIX_W'(i);
      end
      tick;
      wr_addr = 12'h214; wr_data = 9'h014; frame_start = 1'b1;
      sh[12'h214] = 9'h014;
      @(negedge clk);
      n_checks++;
      if (wr_count !== 16'd20) $display("FAIL count_20: got %0d, required 20", wr_count);
      else n_pass++;
      tick;
      wr_valid = 1'b0; frame_start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (wr_count !== 16'd1) $display("FAIL count_restart: got %0d, required 1", wr_count);
      else n_pass++;
      tick;
      push_read(12'h20A);
      tick;
      rd_req = 1'b0;
      repeat (5) tick;
   endtask

   task automatic test_reset_inflight;
      rd_req = 1'b1; rd_addr = 12'h005;
      tick;
      rd_req = 1'b0; rst = 1'b1; wr_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (wr_ready !== 1'b0) $display("FAIL rst_ready: got %b, required 0", wr_ready);
      else n_pass++;
      tick;
      rst = 1'b0; wr_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({rd_data, rd_valid, mem_addr, mem_we, mem_wdata, wr_starve, wr_count} !== '0)
         $display("FAIL rst_outputs: got rd_data=%h rd_valid=%b addr=%h we=%b wdata=%h starve=%b count=%0d, required all 0",
                  rd_data, rd_valid, mem_addr, mem_we, mem_wdata, wr_starve, wr_count);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         tick;
         @(negedge clk);
         n_checks++;
         if (rd_valid !== 1'b0) $display("FAIL rst_discard: got o_Rd_Valid=%b, required 0", rd_valid);
         else n_pass++;
      end
   endtask

   initial begin
      for (int a = 0; a < (1 << ADDR_W); a++) sh[a] = PIX_W'(a + 5);
      test_reset;
      test_reads;
      test_write;
      test_back_to_back;
      test_blank_only;
      test_starve;
      test_count;
      test_reset_inflight;
      n_checks++;
      if (sb_data.size() != 0) $display("FAIL rd_missing: %0d results outstanding, required 0", sb_data.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation ran past 100000 time units, required completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
